countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer_if.sv | 26 ++
 rtl/countdown_timer.sv | 93 +++++++++
 tb/tb_countdown_timer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_if.sv
// Control/status bundle for countdown_timer: strobes and preset in, count and status out.
interface countdown_timer_if #(
    parameter int WIDTH = 8
);
    logic             enable;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             start;
    logic             pause;
    logic [WIDTH-1:0] count;
    logic             running;
    logic             expired;
    logic             done_pulse;

    // Side that issues commands and watches the timer.
    modport master (
        output enable, load, load_value, start, pause,
        input  count, running, expired, done_pulse
    );

    // The timer itself.
    modport slave (
        input  enable, load, load_value, start, pause,
        output count, running, expired, done_pulse
    );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with IDLE/RUN/PAUSED/DONE control and registered status.
// Command priority on every edge: clear > load > pause > start > enable.
module countdown_timer #(
    parameter int WIDTH = 8
) (
    input  logic                clock,
    input  logic                clear,
    countdown_timer_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             running_q, running_d;
    logic             expired_q, expired_d;
    logic             done_pulse_q, done_pulse_d;

    // Next state and count; clear is handled in the register block.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        done_pulse_d = 1'b0;
        if (bus.load) begin
            // Load wins over everything but clear and never decrements.
            count_d = bus.load_value;
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (count_q != '0) begin
                            state_d = RUN;
                        end else begin
                            // Starting an empty timer expires immediately.
                            state_d      = DONE;
                            done_pulse_d = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.pause) begin
                        state_d = PAUSED;
                    end else if (bus.enable && count_q != '0) begin
                        count_d = count_q - WIDTH'(1);
                        if (count_q == WIDTH'(1)) begin
                            state_d      = DONE;
                            done_pulse_d = 1'b1;
                        end
                    end
                end
                PAUSED: begin
                    // A simultaneous pause keeps us parked.
                    if (!bus.pause && bus.start) begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    // Sticky until load or clear.
                end
                default: state_d = IDLE;
            endcase
        end
        running_d = (state_d == RUN);
        expired_d = (state_d == DONE);
    end

    // State and registered outputs, with synchronous clear.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q      <= IDLE;
            count_q      <= '0;
            running_q    <= 1'b0;
            expired_q    <= 1'b0;
            done_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            running_q    <= running_d;
            expired_q    <= expired_d;
            done_pulse_q <= done_pulse_d;
        end
    end

    assign bus.count      = count_q;
    assign bus.running    = running_q;
    assign bus.expired    = expired_q;
    assign bus.done_pulse = done_pulse_q;
endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed vector table, hand sequences, random vs. model.
module tb_countdown_timer;
    localparam int W = 8;

    logic clock = 1'b0;
    logic clear;
    always #5 clock = ~clock;

    countdown_timer_if #(.WIDTH(W)) bus ();

    countdown_timer #(.WIDTH(W)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: count plus "what is it doing" flags.
    int m_cnt;
    bit m_counting, m_parked, m_finished, m_pulse;

    task automatic model_step(input bit clr, ld, input int lv, input bit st, pa, en);
        m_pulse = 0;
        if (clr) begin
            m_cnt = 0; m_counting = 0; m_parked = 0; m_finished = 0;
        end else if (ld) begin
            m_cnt = lv; m_counting = 0; m_parked = 0; m_finished = 0;
        end else if (m_finished) begin
            // nothing leaves DONE except load/clear
        end else if (m_counting) begin
            if (pa) begin
                m_counting = 0; m_parked = 1;
            end else if (en) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    m_counting = 0; m_finished = 1; m_pulse = 1;
                end
            end
        end else if (m_parked) begin
            if (!pa && st) begin
                m_parked = 0; m_counting = 1;
            end
        end else if (st) begin
            if (m_cnt == 0) begin
                m_finished = 1; m_pulse = 1;
            end else begin
                m_counting = 1;
            end
        end
    endtask

    // One clock edge: drive on the falling edge, sample 1ns after rising edge.
    task automatic drive(input bit clr, ld, input int lv, input bit st, pa, en);
        @(negedge clock);
        clear = clr; bus.load = ld; bus.load_value = W'(lv);
        bus.start = st; bus.pause = pa; bus.enable = en;
        @(posedge clock);
        model_step(clr, ld, lv, st, pa, en);
        #1;
    endtask

    task automatic check(input string nm, input int c, input bit r, x, d);
        n_vec++;
        if (bus.count !== W'(c)) begin
            n_err++; $display("FAIL %s count got %0d want %0d", nm, bus.count, c);
        end
        if (bus.running !== r) begin
            n_err++; $display("FAIL %s running got %b want %b", nm, bus.running, r);
        end
        if (bus.expired !== x) begin
            n_err++; $display("FAIL %s expired got %b want %b", nm, bus.expired, x);
        end
        if (bus.done_pulse !== d) begin
            n_err++; $display("FAIL %s done_pulse got %b want %b", nm, bus.done_pulse, d);
        end
    endtask

    task automatic check_model(input string nm);
        check(nm, m_cnt, m_counting, m_finished, m_pulse);
    endtask

    typedef struct {
        bit clr, ld; int lv; bit st, pa, en;
        int c; bit r, x, d;
    } vec_t;

    vec_t tbl[23];

    function automatic vec_t mk(bit clr, ld, int lv, bit st, pa, en, int c, bit r, x, d);
        vec_t v;
        v.clr = clr; v.ld = ld; v.lv = lv; v.st = st; v.pa = pa; v.en = en;
        v.c = c; v.r = r; v.x = x; v.d = d;
        return v;
    endfunction

    initial begin
        int strobes;
        int decs;
        bit hit;

        clear = 1'b1; bus.load = 0; bus.load_value = '0;
        bus.start = 0; bus.pause = 0; bus.enable = 0;

        //           clr ld lv  st pa en   cnt r x d
        tbl[0]  = mk(1, 0, 0,  1, 1, 1,   0, 0, 0, 0); // reset, other inputs ignored
        tbl[1]  = mk(0, 1, 5,  0, 0, 1,   5, 0, 0, 0); // load, no decrement
        tbl[2]  = mk(0, 0, 0,  1, 0, 1,   5, 1, 0, 0); // enable ignored on start edge
        tbl[3]  = mk(0, 0, 0,  0, 0, 1,   4, 1, 0, 0);
        tbl[4]  = mk(0, 0, 0,  1, 0, 1,   3, 1, 0, 0); // start ignored in RUN
        tbl[5]  = mk(0, 0, 0,  0, 0, 0,   3, 1, 0, 0); // hold without enable
        tbl[6]  = mk(0, 0, 0,  0, 0, 1,   2, 1, 0, 0);
        tbl[7]  = mk(0, 0, 0,  0, 0, 1,   1, 1, 0, 0);
        tbl[8]  = mk(0, 0, 0,  0, 0, 1,   0, 0, 1, 1); // 1 -> 0 enters DONE
        tbl[9]  = mk(0, 0, 0,  1, 1, 1,   0, 0, 1, 0); // DONE sticky, pulse once
        tbl[10] = mk(0, 1, 9,  1, 1, 1,   9, 0, 0, 0); // load beats everything
        tbl[11] = mk(0, 0, 0,  0, 0, 1,   9, 0, 0, 0); // enable ignored in IDLE
        tbl[12] = mk(0, 1, 0,  0, 0, 0,   0, 0, 0, 0);
        tbl[13] = mk(0, 0, 0,  1, 0, 0,   0, 0, 1, 1); // start at zero -> DONE
        tbl[14] = mk(0, 0, 0,  1, 0, 1,   0, 0, 1, 0);
        tbl[15] = mk(0, 1, 10, 0, 0, 0,  10, 0, 0, 0);
        tbl[16] = mk(0, 0, 0,  1, 0, 0,  10, 1, 0, 0);
        tbl[17] = mk(0, 0, 0,  0, 0, 1,   9, 1, 0, 0);
        tbl[18] = mk(0, 0, 0,  0, 1, 1,   9, 0, 0, 0); // pause beats enable
        tbl[19] = mk(0, 0, 0,  0, 0, 1,   9, 0, 0, 0); // enable ignored paused
        tbl[20] = mk(0, 0, 0,  1, 0, 1,   9, 1, 0, 0); // resume, enable ignored
        tbl[21] = mk(0, 0, 0,  0, 0, 1,   8, 1, 0, 0);
        tbl[22] = mk(1, 1, 7,  1, 0, 1,   0, 0, 0, 0); // clear mid-run beats load

        for (int i = 0; i < 23; i++) begin
            drive(tbl[i].clr, tbl[i].ld, tbl[i].lv, tbl[i].st, tbl[i].pa, tbl[i].en);
            check($sformatf("tbl%0d", i), tbl[i].c, tbl[i].r, tbl[i].x, tbl[i].d);
        end
        // start after clear: count is 0 -> DONE
        drive(0, 0, 0, 1, 0, 0);
        check("clr_then_start", 0, 0, 1, 1);

        // Sparse enable: load 3, strobe every third cycle, DONE on 3rd strobe.
        drive(0, 1, 3, 0, 0, 0); check_model("sparse_load");
        drive(0, 0, 0, 1, 0, 0); check_model("sparse_start");
        strobes = 0; hit = 0;
        for (int k = 1; k <= 12 && !hit; k++) begin
            drive(0, 0, 0, 0, 0, (k % 3) == 0);
            if ((k % 3) == 0) strobes++;
            check_model($sformatf("sparse%0d", k));
            if (bus.expired === 1'b1) hit = 1;
        end
        n_vec++;
        if (!hit || strobes != 3) begin
            n_err++; $display("FAIL sparse_strobes got %0d (hit=%0d) want 3", strobes, hit);
        end

        // Pause/resume: load 10, run to 6, pause with enable, resume.
        drive(0, 1, 10, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 4; k++) drive(0, 0, 0, 0, 0, 1);
        check("pr_at6", 6, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 1);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 0, 1);
            check($sformatf("pr_hold%0d", k), 6, 0, 0, 0);
        end
        drive(0, 0, 0, 1, 0, 1); check("pr_resume", 6, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 1); check("pr_5", 5, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 1); check("pr_4", 4, 1, 0, 0);

        // Full scale: 255 decrements, no wrap afterwards.
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 255, 0, 0, 0); check("fs_load", 255, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 1); check("fs_start", 255, 1, 0, 0);
        decs = 0;
        while (bus.expired !== 1'b1 && decs < 300) begin
            drive(0, 0, 0, 0, 0, 1);
            decs++;
            if (decs % 32 == 0) check_model($sformatf("fs%0d", decs));
        end
        n_vec++;
        if (decs != 255) begin
            n_err++; $display("FAIL fs_decrements got %0d want 255", decs);
        end
        check("fs_done", 0, 0, 1, 1);
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, k[0], 0, 1);
            check($sformatf("fs_nowrap%0d", k), 0, 0, 1, 0);
        end

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            bit clr, ld, st, pa, en;
            int lv;
            clr = ($urandom_range(0, 99) == 0);
            ld  = ($urandom_range(0, 15) == 0);
            lv  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255))
                                              : int'($urandom_range(0, 12));
            st  = ($urandom_range(0, 3) == 0);
            pa  = ($urandom_range(0, 9) == 0);
            en  = $urandom_range(0, 1);
            drive(clr, ld, lv, st, pa, en);
            check_model($sformatf("rnd%0d", k));
            if (bus.running === 1'b1 && bus.expired === 1'b1) begin
                n_err++; $display("FAIL rnd_excl running and expired both 1, want exclusive");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
